sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
- Reads one sprite out of sprite storage, one 4-bit pixel per cycle, through the storage's registered read port (1-cycle latency).
- Writes the visible, non-transparent pixels into the framebuffer write port at a given screen position, clipping at all four screen edges.
- Consumer side of the sprite store: the SPI loader fills the store, this block drains it into the frame.

Parameters:
- SPRITE_NUM, 16, number of sprite slots in storage
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- TRANSP, 4'h0, palette index treated as transparent (never written)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- sprite_id  in  clog2(SPRITE_NUM)  sprite slot to draw; latched on start
- pos_x  in  11 signed  screen X of sprite top-left; latched on start
- pos_y  in  11 signed  screen Y of sprite top-left; latched on start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last pixel has been handled
- sprite_select  out  clog2(SPRITE_NUM)  to storage; the latched sprite_id
- r_en  out  1  storage read enable
- r_addr  out  clog2(SPRITE_W*SPRITE_H)+1  storage pixel address, sy*SPRITE_W+sx
- r_data  in  4  storage pixel, valid the cycle after r_en
- fb_ready  in  1  framebuffer can accept a write this cycle
- fb_w_en  out  1  framebuffer write strobe
- fb_w_addr  out  clog2(FB_W*FB_H)  (pos_y+sy)*FB_W+(pos_x+sx)
- fb_w_data  out  4  pixel index

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, r_en and fb_w_en are 0; counters, addresses, sprite_select and fb_w_data are 0. Reset asserted mid-operation aborts with no further writes and no done pulse.
- States:
  - IDLE: start=1 latches id, x and y, clears sx and sy, then goes to RUN.
  - RUN: fetches pixels; goes to DRAIN after the read of (SPRITE_W-1, SPRITE_H-1) is issued.
  - DRAIN: the last pixel in the stage is resolved, then done pulses and the block returns to IDLE.
- start while busy is ignored: no relatch, no effect.
- Pipeline, two stages:
  - Stage F: r_en issues the address of the current (sx, sy).
  - Stage P: the cycle after, holds r_data together with its sx and sy, delayed to match.
- Advance rule: adv = !(P_valid && P_write && !fb_ready). r_en = RUN && adv. The counters step only on adv.
- Counter stepping: sx increments; when it wraps at SPRITE_W, sy increments.
- Stall: when adv=0, r_en=0, so the storage holds r_data and stage P keeps its pixel stable.
- Write qualification: P_write = (r_data != TRANSP) && 0 <= pos_x+sx < FB_W && 0 <= pos_y+sy < FB_H. Screen coordinates are computed as 12-bit signed values to avoid overflow.
- fb_w_en = P_valid && P_write. It stays high during a stall, with address and data held, until fb_ready=1. The write completes on the edge where fb_w_en && fb_ready.
- Skipped pixels (transparent or clipped) consume one cycle and generate no write.
- Latency: with fb_ready held at 1, start accepted at edge 0 gives:
  - r_en high in cycles 1..N, where N = SPRITE_W*SPRITE_H;
  - pixel writes in cycles 2..N+1;
  - done in cycle N+2, with busy low from cycle N+2.
- Fully off-screen sprite: all N reads still occur, zero writes, done at N+2.

Decomposition:
- Shared package params.vh holds SPRITE_NUM, SPRITE_W, SPRITE_H, SPRITE_SIZE, SPRITE_ADDR_SIZE, FB_W, FB_H, TRANSP and the state enum (IDLE, RUN, DRAIN).
- One natural sub-module, blit_clip, is combinational: pos and sx/sy in, visible flag and fb address out.

Test Plan:
- Sprite 3 all-opaque (index 5), pos (0,0), fb_ready=1 -> 1024 writes: first addr 0, last addr 31*320+31=9951, data 5; done in cycle 1026.
- Checkerboard with index 0 on even pixels, pos (10,10) -> exactly 512 writes, none carrying data 0; first write at addr 10*320+11=3211.
- pos (-4,-4) -> 28*28=784 writes; first write address 0 (sx=4, sy=4); no write with a negative coordinate.
- pos (300,230) -> 20*10=200 writes; maximum address 239*320+319=76799.
- pos (400,0) -> 0 writes; done still in cycle 1026.
- fb_ready low for 3 cycles during the 5th write -> fb_w_addr and fb_w_data stable throughout, r_en=0, no pixel lost or duplicated; done delayed by exactly 3 cycles.
- start pulsed during busy with different id and pos -> ignored.
- reset_n low mid-RUN -> all outputs 0 immediately; no done pulse.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared sizes, state encoding and pixel-address helper for the sprite blitter.
package sprite_blitter_pkg;

  localparam int unsigned SPRITE_NUM       = 16;
  localparam int unsigned SPRITE_W         = 32;
  localparam int unsigned SPRITE_H         = 32;
  localparam int unsigned SPRITE_SIZE      = SPRITE_W * SPRITE_H;
  localparam int unsigned SPRITE_ADDR_SIZE = $clog2(SPRITE_SIZE) + 1;
  localparam int unsigned FB_W             = 320;
  localparam int unsigned FB_H             = 240;

  localparam int unsigned SEL_W     = $clog2(SPRITE_NUM);
  localparam int unsigned SX_W      = $clog2(SPRITE_W);
  localparam int unsigned SY_W      = $clog2(SPRITE_H);
  localparam int unsigned FB_ADDR_W = $clog2(FB_W * FB_H);
  localparam int unsigned FBX_W     = $clog2(FB_W);
  localparam int unsigned FBY_W     = $clog2(FB_H);
  localparam int unsigned POS_W     = 11;
  localparam int unsigned SCR_W     = POS_W + 1;
  localparam int unsigned PIX_W     = 4;

  localparam logic [PIX_W-1:0] TRANSP = 4'h0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Sprite-local coordinates of the pixel currently held in the resolve stage.
  typedef struct packed {
    logic            valid;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;
  } pix_tag_t;

  function automatic logic [SPRITE_ADDR_SIZE-1:0] pix_addr(input logic [SX_W-1:0] x,
                                                           input logic [SY_W-1:0] y);
    return SPRITE_ADDR_SIZE'(y) * SPRITE_ADDR_SIZE'(SPRITE_W) + SPRITE_ADDR_SIZE'(x);
  endfunction

endpackage

// File: rtl/blit_clip.sv
// Maps a sprite pixel to screen space: visibility against all four edges and
// the linear framebuffer address (zero when off-screen).
module blit_clip
  import sprite_blitter_pkg::*;
(
  input  logic signed [POS_W-1:0]     pos_x,
  input  logic signed [POS_W-1:0]     pos_y,
  input  logic        [SX_W-1:0]      sx,
  input  logic        [SY_W-1:0]      sy,
  output logic                        visible,
  output logic        [FB_ADDR_W-1:0] fb_addr
);

  logic signed [SCR_W-1:0] scr_x;
  logic signed [SCR_W-1:0] scr_y;
  logic                    on_x;
  logic                    on_y;

  // One extra bit so pos + offset can never wrap.
  assign scr_x = $signed({pos_x[POS_W-1], pos_x}) + $signed(SCR_W'(sx));
  assign scr_y = $signed({pos_y[POS_W-1], pos_y}) + $signed(SCR_W'(sy));

  assign on_x = !scr_x[SCR_W-1] && (scr_x < $signed(SCR_W'(FB_W)));
  assign on_y = !scr_y[SCR_W-1] && (scr_y < $signed(SCR_W'(FB_H)));

  assign visible = on_x && on_y;
  assign fb_addr = visible ? (FB_ADDR_W'(scr_y[FBY_W-1:0]) * FB_ADDR_W'(FB_W)
                              + FB_ADDR_W'(scr_x[FBX_W-1:0]))
                           : '0;

endmodule

// File: rtl/sprite_blitter.sv
// Streams one sprite from storage into the framebuffer, one pixel per cycle,
// skipping transparent and off-screen pixels and stalling on fb_ready.
module sprite_blitter
  import sprite_blitter_pkg::*;
(
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic        [SEL_W-1:0]            sprite_id,
  input  logic signed [POS_W-1:0]            pos_x,
  input  logic signed [POS_W-1:0]            pos_y,
  output logic                               busy,
  output logic                               done,
  output logic        [SEL_W-1:0]            sprite_select,
  output logic                               r_en,
  output logic        [SPRITE_ADDR_SIZE-1:0] r_addr,
  input  logic        [PIX_W-1:0]            r_data,
  input  logic                               fb_ready,
  output logic                               fb_w_en,
  output logic        [FB_ADDR_W-1:0]        fb_w_addr,
  output logic        [PIX_W-1:0]            fb_w_data
);

  state_t                   state;
  logic signed [POS_W-1:0]  px;
  logic signed [POS_W-1:0]  py;
  logic        [SX_W-1:0]   sx;
  logic        [SY_W-1:0]   sy;
  pix_tag_t                 p;

  logic                     p_vis;
  logic                     p_write;
  logic                     adv;
  logic                     sx_last;
  logic                     last_pix;
  logic        [FB_ADDR_W-1:0] p_addr;

  blit_clip u_clip (
    .pos_x   (px),
    .pos_y   (py),
    .sx      (p.sx),
    .sy      (p.sy),
    .visible (p_vis),
    .fb_addr (p_addr)
  );

  // The whole pipeline freezes while a pending write waits on the framebuffer;
  // storage keeps r_data because no new read is issued.
  assign p_write  = p.valid && p_vis && (r_data != TRANSP);
  assign adv      = !(p_write && !fb_ready);
  assign r_en     = (state == RUN) && adv;
  assign r_addr   = pix_addr(sx, sy);
  assign sx_last  = (sx == SX_W'(SPRITE_W - 1));
  assign last_pix = sx_last && (sy == SY_W'(SPRITE_H - 1));

  assign fb_w_en   = p_write;
  assign fb_w_addr = p_write ? p_addr : '0;
  assign fb_w_data = p_write ? r_data : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      sprite_select <= '0;
      px            <= '0;
      py            <= '0;
      sx            <= '0;
      sy            <= '0;
      p             <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sprite_select <= sprite_id;
            px            <= pos_x;
            py            <= pos_y;
            sx            <= '0;
            sy            <= '0;
            busy          <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            p.valid <= 1'b1;
            p.sx    <= sx;
            p.sy    <= sy;
            sx      <= sx + SX_W'(1);
            if (sx_last) sy <= sy + SY_W'(1);
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (adv) begin
            p.valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
